dcpu_alu_seq: RTL

Parametrised, multi-cycle successor to the combinational DCPU ALU. Executes all DCPU-16 basic arithmetic/logic opcodes on WIDTH-bit operands and produces both the result and the full overflow (O/EX) register value. MUL and DIV/MOD run iteratively. Results are held in registers and transferred by valid/ready handshakes. Sits between operand decode and the register-file/O writeback stage.

---
 rtl/dcpu_alu_pkg.sv | 54 +++++
 rtl/dcpu_alu_seq_if.sv | 34 +++
 rtl/dcpu_alu_divider.sv | 111 +++++++++++
 rtl/dcpu_alu_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu_alu_pkg.sv
// Shared definitions for the sequential DCPU-16 ALU.
//
// Contents:
//   opcode_t / OP_*     : 4-bit basic-opcode codes (SET..XOR); OP_NONE marks unsupported
//   alu_state_e         : control states of dcpu_alu_seq (idle, multiply, divide, done)
//   is_single_cycle()   : opcode completes on the accept edge
//   writes_overflow()   : opcode updates the O/EX register
//
// Build option: DCPU_ALU_FAST_MUL_EN makes MUL a single-cycle opcode.
package dcpu_alu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NONE = 4'h0;
  localparam opcode_t OP_SET  = 4'h1;
  localparam opcode_t OP_ADD  = 4'h2;
  localparam opcode_t OP_SUB  = 4'h3;
  localparam opcode_t OP_MUL  = 4'h4;
  localparam opcode_t OP_DIV  = 4'h5;
  localparam opcode_t OP_MOD  = 4'h6;
  localparam opcode_t OP_SHL  = 4'h7;
  localparam opcode_t OP_SHR  = 4'h8;
  localparam opcode_t OP_AND  = 4'h9;
  localparam opcode_t OP_BOR  = 4'hA;
  localparam opcode_t OP_XOR  = 4'hB;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } alu_state_e;

  // Division by zero short-circuits to a zero result, so it never enters the divider.
  function automatic logic is_single_cycle(opcode_t op, logic b_zero);
    logic single;
    single = 1'b1;
    if ((op == OP_DIV) || (op == OP_MOD)) begin
      single = b_zero;
    end
`ifndef DCPU_ALU_FAST_MUL_EN
    if (op == OP_MUL) begin
      single = 1'b0;
    end
`endif
    return single;
  endfunction

  function automatic logic writes_overflow(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
           (op == OP_DIV) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/dcpu_alu_seq_if.sv
// Request/result handshake bundle between operand decode, the ALU and writeback.
//
// Request channel : in_valid, in_ready, in_opcode[OPW], in_a[WIDTH], in_b[WIDTH]
// Result channel  : out_valid, out_ready, out_result[WIDTH], out_overflow[WIDTH],
//                   out_overflow_we
// master : decode/writeback side (drives requests, accepts results)
// slave  : ALU side
interface dcpu_alu_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_overflow;
  logic             out_overflow_we;

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_overflow_we
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_overflow_we
  );

endinterface

// File: rtl/dcpu_alu_divider.sv
// Iterative restoring divider for the DCPU ALU.
//
// Divides {dividend, WIDTH zeros} by divisor over 2*WIDTH iterations, one quotient bit per
// cycle. The upper quotient half is dividend/divisor, the lower half is the binary fraction
// and the partial remainder after the first WIDTH iterations is dividend%divisor.
//
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (aborts a running division)
//   start_i       : load operands; the first iteration runs on this same edge
//   dividend_i    : dividend, sampled with start_i
//   divisor_i     : divisor (non-zero), sampled with start_i
//   done_o        : one-cycle pulse, results valid while high and held afterwards
//   quotient_o    : dividend / divisor
//   remainder_o   : dividend % divisor
//   fraction_o    : ((dividend << WIDTH) / divisor) mod 2^WIDTH
module dcpu_alu_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic [WIDTH-1:0] fraction_o
);

  localparam int unsigned Iter = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(Iter);

  logic            busy_q;
  logic            done_q;
  logic [CntW-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] remainder_q;
  logic [Iter-1:0]  dvd_q;
  logic [Iter-1:0]  quo_q;

  logic             run;
  logic [WIDTH-1:0] src_rem;
  logic [WIDTH-1:0] src_div;
  logic [Iter-1:0]  src_dvd;
  logic [Iter-1:0]  src_quo;
  logic [CntW-1:0]  src_cnt;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] new_rem;

  // Iteration operands come straight from the inputs on the start edge so that the first
  // step costs no extra cycle.
  always_comb begin
    run = start_i | busy_q;
    if (start_i) begin
      src_rem = '0;
      src_div = divisor_i;
      src_dvd = {dividend_i, {WIDTH{1'b0}}};
      src_quo = '0;
      src_cnt = '0;
    end else begin
      src_rem = rem_q;
      src_div = divisor_q;
      src_dvd = dvd_q;
      src_quo = quo_q;
      src_cnt = cnt_q;
    end
    trial = {src_rem, src_dvd[Iter-1]};
    qbit  = (trial >= {1'b0, src_div});
    // trial < 2*divisor, so the true difference always fits in WIDTH bits.
    new_rem = qbit ? (trial[WIDTH-1:0] - src_div) : trial[WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      remainder_q <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (run) begin
        rem_q     <= new_rem;
        divisor_q <= src_div;
        dvd_q     <= src_dvd << 1;
        quo_q     <= {src_quo[Iter-2:0], qbit};
        cnt_q     <= src_cnt + 1'b1;
        if (src_cnt == CntW'(WIDTH - 1)) begin
          remainder_q <= new_rem;
        end
        if (src_cnt == CntW'(Iter - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          busy_q <= 1'b1;
        end
      end
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q[Iter-1:WIDTH];
  assign fraction_o  = quo_q[WIDTH-1:0];
  assign remainder_o = remainder_q;

endmodule

// File: rtl/dcpu_alu_seq.sv
// Multi-cycle DCPU-16 ALU with valid/ready request and result channels.
//
// Executes SET, ADD, SUB, MUL, DIV, MOD, SHL, SHR, AND, BOR, XOR on WIDTH-bit unsigned
// operands and returns the result plus the new O/EX register value. MUL is a shift-add
// multiplier (one bit per cycle), DIV/MOD use dcpu_alu_divider; all other opcodes finish
// on the accept edge. Results are registered and held until out_ready.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, aborts any operation in flight
//   bus  : dcpu_alu_seq_if.slave (request in_*, result out_*)
//
// Build option: `define DCPU_ALU_FAST_MUL_EN for a combinational single-cycle multiplier.
module dcpu_alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 4
) (
  input logic           clk,
  input logic           rst,
  dcpu_alu_seq_if.slave bus
);

  import dcpu_alu_pkg::*;

  localparam int unsigned DoubleW = 2 * WIDTH;
  localparam int unsigned MulCntW = $clog2(WIDTH);
  localparam int unsigned OpPadW  = (OPW > 4) ? OPW : 4;

  alu_state_e        state_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  result_q;
  logic [WIDTH-1:0]  ov_q;
  logic              ov_we_q;
  logic [DoubleW-1:0] prod_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [MulCntW-1:0] mul_cnt_q;
  logic              mod_q;

  logic              in_ready;
  logic              accept;
  logic [OpPadW-1:0] op_ext;
  opcode_t           op;
  logic              b_zero;
  logic              single;
  logic              sc_we;

  // Opcodes wider than the DCPU field map to the unsupported code.
  assign op_ext = OpPadW'(bus.in_opcode);
  assign op     = ((op_ext >> 4) == '0) ? op_ext[3:0] : OP_NONE;
  assign b_zero = (bus.in_b == '0);
  assign single = is_single_cycle(op, b_zero);
  assign sc_we  = writes_overflow(op);

  assign in_ready = (state_q == StIdle);
  assign accept   = bus.in_valid & in_ready;

  // ---------------------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the request operands
  // ---------------------------------------------------------------------------------------
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic               shift_big;
  logic [DoubleW-1:0] shl_wide;
  logic [DoubleW-1:0] shr_wide;
  logic [WIDTH-1:0]   sc_result;
  logic [WIDTH-1:0]   sc_ov;

  assign add_sum   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign sub_diff  = {1'b0, bus.in_a} - {1'b0, bus.in_b};
  assign shift_big = (bus.in_b >= WIDTH'(DoubleW));
  // Shifting a double-width copy yields the result and the spilled O bits in one go.
  assign shl_wide  = shift_big ? '0 : ({{WIDTH{1'b0}}, bus.in_a} << bus.in_b);
  assign shr_wide  = shift_big ? '0 : ({bus.in_a, {WIDTH{1'b0}}} >> bus.in_b);

`ifdef DCPU_ALU_FAST_MUL_EN
  logic [DoubleW-1:0] fast_prod;
  assign fast_prod = DoubleW'(bus.in_a) * DoubleW'(bus.in_b);
`endif

  always_comb begin
    sc_result = '0;
    sc_ov     = '0;
    case (op)
      OP_SET: sc_result = bus.in_b;
      OP_ADD: begin
        sc_result = add_sum[WIDTH-1:0];
        sc_ov     = WIDTH'(add_sum[WIDTH]);
      end
      OP_SUB: begin
        sc_result = sub_diff[WIDTH-1:0];
        sc_ov     = {WIDTH{sub_diff[WIDTH]}};
      end
`ifdef DCPU_ALU_FAST_MUL_EN
      OP_MUL: begin
        sc_result = fast_prod[WIDTH-1:0];
        sc_ov     = fast_prod[DoubleW-1:WIDTH];
      end
`endif
      OP_SHL: begin
        sc_result = shl_wide[WIDTH-1:0];
        sc_ov     = shl_wide[DoubleW-1:WIDTH];
      end
      OP_SHR: begin
        sc_result = shr_wide[DoubleW-1:WIDTH];
        sc_ov     = shr_wide[WIDTH-1:0];
      end
      OP_AND: sc_result = bus.in_a & bus.in_b;
      OP_BOR: sc_result = bus.in_a | bus.in_b;
      OP_XOR: sc_result = bus.in_a ^ bus.in_b;
      // DIV/MOD by zero and unsupported opcodes produce zero.
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Shift-add multiplier step: multiplier sits in the low half of prod_q and is consumed
  // LSB first while partial sums accumulate into the high half.
  // ---------------------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [DoubleW-1:0] mul_next;

  assign mul_sum  = {1'b0, prod_q[DoubleW-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  // ---------------------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------------------
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_frac;

  assign div_start = accept & ~single & ((op == OP_DIV) | (op == OP_MOD));

  dcpu_alu_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (div_start),
    .dividend_i  (bus.in_a),
    .divisor_i   (bus.in_b),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .fraction_o  (div_frac)
  );

  // ---------------------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ov_q        <= '0;
      ov_we_q     <= 1'b0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mul_cnt_q   <= '0;
      mod_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (single) begin
              result_q    <= sc_result;
              ov_q        <= sc_we ? sc_ov : '0;
              ov_we_q     <= sc_we;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else if (op == OP_MUL) begin
              prod_q    <= {{WIDTH{1'b0}}, bus.in_a};
              mcand_q   <= bus.in_b;
              mul_cnt_q <= '0;
              state_q   <= StMul;
            end else begin
              mod_q   <= (op == OP_MOD);
              state_q <= StDiv;
            end
          end
        end
        StMul: begin
          prod_q    <= mul_next;
          mul_cnt_q <= mul_cnt_q + 1'b1;
          if (mul_cnt_q == MulCntW'(WIDTH - 1)) begin
            result_q    <= mul_next[WIDTH-1:0];
            ov_q        <= mul_next[DoubleW-1:WIDTH];
            ov_we_q     <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDiv: begin
          if (div_done) begin
            result_q    <= mod_q ? div_rem : div_quo;
            ov_q        <= mod_q ? '0 : div_frac;
            ov_we_q     <= ~mod_q;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_result      = result_q;
  assign bus.out_overflow    = ov_q;
  assign bus.out_overflow_we = ov_we_q;

endmodule
